// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Core-side bus of the shared ALU arbiter. Carries both cores'
//               requests, opcodes, operands and flushes into the arbiter, and
//               the grants plus the shared result bus back out.
//   req       2         per-core request, bit i = core i
//   aluop_in  2*OP_W    per-core opcode, core i at [i*OP_W +: OP_W]
//   portA_in  2*DATA_W  per-core operand A, sliced the same way
//   portB_in  2*DATA_W  per-core operand B, sliced the same way
//   flush     2         per-core cancel of in-flight ops
//   gnt       2         per-core grant (combinational, one-hot or zero)
//   rvalid    2         per-core result valid pulse
//   rdata     DATA_W    shared result, qualified by rvalid
//   rflags    3         {negative, zero, overflow} captured with rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic [1:0]          req;
  logic [2*OP_W-1:0]   aluop_in;
  logic [2*DATA_W-1:0] portA_in;
  logic [2*DATA_W-1:0] portB_in;
  logic [1:0]          flush;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          rflags;

  // Cores side
  modport master (
    output req, aluop_in, portA_in, portB_in, flush,
    input  gnt, rvalid, rdata, rflags
  );

  // Arbiter side
  modport slave (
    input  req, aluop_in, portA_in, portB_in, flush,
    output gnt, rvalid, rdata, rflags
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two cores. Round-robin grant (one op
//               per cycle), a registered issue stage driving the ALU, and a
//               registered response stage returning the result to the owning
//               core two cycles after the transfer. Per-core flush kills that
//               core's op while it sits in the issue stage.
//   CLK           in   clock, rising edge
//   RST           in   asynchronous active-high reset
//   bus           slave core-side request/grant/response bus
//   alu_aluop     out  opcode to ALU
//   alu_portA     out  operand A to ALU
//   alu_portB     out  operand B to ALU
//   alu_portOut   in   ALU result
//   alu_negative  in   ALU negative flag
//   alu_zero      in   ALU zero flag
//   alu_overflow  in   ALU overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  alu_arbiter_if.slave           bus,
  output logic [OP_W-1:0]        alu_aluop,
  output logic [DATA_W-1:0]      alu_portA,
  output logic [DATA_W-1:0]      alu_portB,
  input  wire logic [DATA_W-1:0] alu_portOut,
  input  wire logic              alu_negative,
  input  wire logic              alu_zero,
  input  wire logic              alu_overflow
);

  // Arbitration state: id of the core that won the most recent transfer.
  logic              last_gnt_q, last_gnt_d;

  // Issue stage
  logic              iss_v_q, iss_v_d;
  logic              iss_owner_q, iss_owner_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;
  logic [DATA_W-1:0] iss_a_q, iss_a_d;
  logic [DATA_W-1:0] iss_b_q, iss_b_d;

  // Response stage
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rflags_q, rflags_d;

  // Combinational helpers
  logic [1:0]        w_req_eff;
  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic              w_gnt_id;
  logic              w_resp;

  always_comb begin
    // A flushed core cannot be granted this cycle; its slot goes to the other.
    w_req_eff = bus.req & ~bus.flush;
    w_gnt     = w_req_eff;
    if (&w_req_eff) begin
      w_gnt = last_gnt_q ? 2'b01 : 2'b10;
    end
    w_xfer   = |w_gnt;
    w_gnt_id = w_gnt[1];

    last_gnt_d  = last_gnt_q;
    iss_v_d     = w_xfer;
    iss_owner_d = iss_owner_q;
    iss_op_d    = iss_op_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    if (w_xfer) begin
      last_gnt_d  = w_gnt_id;
      iss_owner_d = w_gnt_id;
      iss_op_d    = w_gnt_id ? bus.aluop_in[2*OP_W-1:OP_W]     : bus.aluop_in[OP_W-1:0];
      iss_a_d     = w_gnt_id ? bus.portA_in[2*DATA_W-1:DATA_W] : bus.portA_in[DATA_W-1:0];
      iss_b_d     = w_gnt_id ? bus.portB_in[2*DATA_W-1:DATA_W] : bus.portB_in[DATA_W-1:0];
    end

    // The owner's flush only matters while the op is in the issue stage;
    // an already registered response is never retracted.
    w_resp   = iss_v_q & ~bus.flush[iss_owner_q];
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    rflags_d = rflags_q;
    if (w_resp) begin
      rvalid_d[iss_owner_q] = 1'b1;
      rdata_d               = alu_portOut;
      rflags_d              = {alu_negative, alu_zero, alu_overflow};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_gnt_q  <= 1'b1;  // core 0 wins the first contention
      iss_v_q     <= 1'b0;
      iss_owner_q <= 1'b0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      rflags_q    <= 3'b000;
    end else begin
      last_gnt_q  <= last_gnt_d;
      iss_v_q     <= iss_v_d;
      iss_owner_q <= iss_owner_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rflags_q    <= rflags_d;
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rflags = rflags_q;

  assign alu_aluop  = iss_op_q;
  assign alu_portA  = iss_a_q;
  assign alu_portB  = iss_b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A small ALU model sits
//               on the ALU ports; single-op vectors come from a table, and
//               contention, flush, fairness and reset are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_AND = 4'd2;
  localparam logic [3:0] c_ALU_OR  = 4'd3;
  localparam logic [3:0] c_ALU_SLT = 4'd4;
  localparam logic [3:0] c_ALU_UND = 4'd15;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  alu_aluop;
  logic [31:0] alu_portA, alu_portB, alu_portOut;
  logic        alu_negative, alu_zero, alu_overflow;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_arbiter_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .alu_aluop    (alu_aluop),
    .alu_portA    (alu_portA),
    .alu_portB    (alu_portB),
    .alu_portOut  (alu_portOut),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
  );

  // Reference ALU hooked to the DUT's ALU ports
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_aluop)
      c_ALU_ADD: begin
        alu_portOut  = alu_portA + alu_portB;
        alu_overflow = (alu_portA[31] == alu_portB[31]) && (alu_portOut[31] != alu_portA[31]);
      end
      c_ALU_SUB: begin
        alu_portOut  = alu_portA - alu_portB;
        alu_overflow = (alu_portA[31] != alu_portB[31]) && (alu_portOut[31] != alu_portA[31]);
      end
      c_ALU_AND: alu_portOut = alu_portA & alu_portB;
      c_ALU_OR:  alu_portOut = alu_portA | alu_portB;
      c_ALU_SLT: alu_portOut = {31'b0, $signed(alu_portA) < $signed(alu_portB)};
      default: begin
        alu_portOut  = 32'hDEADBEEF;
        alu_overflow = 1'b1;
      end
    endcase
    alu_negative = alu_portOut[31];
    alu_zero     = (alu_portOut == 32'd0);
  end

  typedef struct {
    logic        core;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rdata;
    logic [2:0]  flags;  // {negative, zero, overflow}
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_op(input logic core, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (core) begin
      bus.aluop_in[7:4]  = op;
      bus.portA_in[63:32] = a;
      bus.portB_in[63:32] = b;
    end else begin
      bus.aluop_in[3:0]  = op;
      bus.portA_in[31:0] = a;
      bus.portB_in[31:0] = b;
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int losses;
    logic [1:0] oh;

    vecs[0] = '{1'b0, c_ALU_ADD, 32'd5,        32'd7,        32'd12,       3'b000};
    vecs[1] = '{1'b1, c_ALU_ADD, 32'h80000000, 32'h80000000, 32'd0,        3'b011};
    vecs[2] = '{1'b0, c_ALU_OR,  32'hF0,       32'h0F,       32'hFF,       3'b000};
    vecs[3] = '{1'b1, c_ALU_SUB, 32'd3,        32'd3,        32'd0,        3'b010};
    vecs[4] = '{1'b0, c_ALU_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        3'b000};
    vecs[5] = '{1'b1, c_ALU_UND, 32'd1,        32'd2,        32'hDEADBEEF, 3'b101};
    vecs[6] = '{1'b0, c_ALU_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 3'b100};

    bus.req = 2'b00; bus.flush = 2'b00;
    bus.aluop_in = '0; bus.portA_in = '0; bus.portB_in = '0;
    RST = 1'b1;

    // Reset state and combinational grant while in reset
    @(negedge CLK);
    chk("rst_rvalid", bus.rvalid, 2'b00);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rflags", bus.rflags, 3'b000);
    chk("rst_aluop", alu_aluop, 4'd0);
    chk("rst_portA", alu_portA, 32'd0);
    bus.req = 2'b11; #1;
    chk("rst_gnt_contend", bus.gnt, 2'b01);
    bus.flush = 2'b01; #1;
    chk("flush_suppress_both", bus.gnt, 2'b10);
    bus.req = 2'b01; #1;
    chk("flush_suppress_only", bus.gnt, 2'b00);
    bus.req = 2'b00; bus.flush = 2'b00;

    @(posedge CLK); #1;
    RST = 1'b0;

    // Contention from reset: grants alternate, responses in grant order
    drive_op(1'b0, c_ALU_SUB, 32'd3, 32'd3);
    drive_op(1'b1, c_ALU_OR, 32'hF0, 32'h0F);
    for (int k = 0; k < 9; k++) begin
      bus.req = (k < 6) ? 2'b11 : 2'b00;
      @(negedge CLK);
      chk("contend_gnt", bus.gnt, (k >= 6) ? 2'b00 : ((k % 2) ? 2'b10 : 2'b01));
      if (k >= 2 && k < 8) begin
        chk("contend_rvalid", bus.rvalid, (k % 2) ? 2'b10 : 2'b01);
        chk("contend_rdata", bus.rdata, (k % 2) ? 32'hFF : 32'd0);
        chk("contend_rflags", bus.rflags, (k % 2) ? 3'b000 : 3'b010);
      end else begin
        chk("contend_idle", bus.rvalid, 2'b00);
      end
      next_cycle();
    end

    // Table of single transactions
    for (int i = 0; i < 7; i++) begin
      oh = vecs[i].core ? 2'b10 : 2'b01;
      drive_op(vecs[i].core, vecs[i].op, vecs[i].a, vecs[i].b);
      bus.req = oh;
      @(negedge CLK);
      chk("vec_gnt", bus.gnt, oh);
      next_cycle();
      bus.req = 2'b00;
      @(negedge CLK);
      chk("vec_alu_aluop", alu_aluop, vecs[i].op);
      chk("vec_alu_portA", alu_portA, vecs[i].a);
      chk("vec_alu_portB", alu_portB, vecs[i].b);
      chk("vec_rvalid_early", bus.rvalid, 2'b00);
      next_cycle();
      @(negedge CLK);
      chk("vec_rvalid", bus.rvalid, oh);
      chk("vec_rdata", bus.rdata, vecs[i].rdata);
      chk("vec_rflags", bus.rflags, vecs[i].flags);
      next_cycle();
      @(negedge CLK);
      chk("vec_rvalid_pulse", bus.rvalid, 2'b00);
      chk("vec_rdata_hold", bus.rdata, vecs[i].rdata);
      next_cycle();
    end

    // Flush of core 1 op in issue stage; core 0 op behind it survives
    drive_op(1'b1, c_ALU_SLT, 32'hFFFFFFFF, 32'd1);
    bus.req = 2'b10;
    @(negedge CLK);
    chk("flush_gnt1", bus.gnt, 2'b10);
    next_cycle();
    drive_op(1'b0, c_ALU_ADD, 32'd2, 32'd3);
    bus.req = 2'b01; bus.flush = 2'b10;
    @(negedge CLK);
    chk("flush_gnt0", bus.gnt, 2'b01);
    next_cycle();
    bus.req = 2'b00; bus.flush = 2'b00;
    @(negedge CLK);
    chk("flush_dropped", bus.rvalid, 2'b00);
    next_cycle();
    @(negedge CLK);
    chk("flush_other_rvalid", bus.rvalid, 2'b01);
    chk("flush_other_rdata", bus.rdata, 32'd5);
    next_cycle();

    // Flush while the response is already visible does not retract it
    drive_op(1'b1, c_ALU_OR, 32'd1, 32'd2);
    bus.req = 2'b10;
    next_cycle();
    bus.req = 2'b00;
    next_cycle();
    bus.flush = 2'b10;
    @(negedge CLK);
    chk("no_retract_rvalid", bus.rvalid, 2'b10);
    chk("no_retract_rdata", bus.rdata, 32'd3);
    next_cycle();
    bus.flush = 2'b00;

    // Fairness: core 1 streams, core 0 idle then requesting continuously
    drive_op(1'b1, c_ALU_AND, 32'hFF, 32'h0F);
    drive_op(1'b0, c_ALU_ADD, 32'd1, 32'd1);
    bus.req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("stream_gnt1", bus.gnt, 2'b10);
      next_cycle();
    end
    bus.req = 2'b11;
    losses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("fair_gnt", bus.gnt, (k % 2) ? 2'b10 : 2'b01);
      losses = bus.gnt[0] ? 0 : losses + 1;
      chk("fair_no_starve", (losses < 2), 1'b1);
      next_cycle();
    end
    bus.req = 2'b00;
    next_cycle();
    next_cycle();

    // Reset mid-stream with two ops in flight
    drive_op(1'b0, c_ALU_ADD, 32'd5, 32'd7);
    drive_op(1'b1, c_ALU_OR, 32'hF0, 32'h0F);
    bus.req = 2'b11;
    next_cycle();
    next_cycle();
    bus.req = 2'b00;
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_rvalid", bus.rvalid, 2'b00);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_rflags", bus.rflags, 3'b000);
    next_cycle();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("postrst_quiet", bus.rvalid, 2'b00);
      next_cycle();
    end
    bus.req = 2'b11;
    @(negedge CLK);
    chk("postrst_contend", bus.gnt, 2'b01);
    next_cycle();
    bus.req = 2'b00;
    next_cycle();
    @(negedge CLK);
    chk("postrst_rvalid", bus.rvalid, 2'b01);
    chk("postrst_rdata", bus.rdata, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath between the two cores of the dual-core CPU.
- Takes operation requests from core 0 and core 1 and grants one per cycle using round-robin priority.
- Registers the granted operands into an issue stage that drives the ALU, then registers the ALU result and returns it to the owning core.
- Fully pipelined: one op per cycle throughput, fixed 2-cycle latency, with per-core flush of in-flight ops.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU port width.
- OP_W, 4, aluop width; must match aluop_t in cpu_types_pkg.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  2  per-core request; bit i = core i.
- aluop_in  in  2*OP_W  per-core opcode; core i occupies slice [i*OP_W +: OP_W].
- portA_in  in  2*DATA_W  per-core operand A, sliced the same way.
- portB_in  in  2*DATA_W  per-core operand B, sliced the same way.
- flush  in  2  per-core cancel of that core's in-flight ops.
- gnt  out  2  per-core grant, combinational, one-hot or zero.
- alu_aluop  out  OP_W  to ALU aluop.
- alu_portA  out  DATA_W  to ALU portA.
- alu_portB  out  DATA_W  to ALU portB.
- alu_portOut  in  DATA_W  from ALU.
- alu_negative  in  1  from ALU.
- alu_zero  in  1  from ALU.
- alu_overflow  in  1  from ALU.
- rvalid  out  2  per-core result valid, one-cycle pulse.
- rdata  out  DATA_W  result; shared bus, qualified by rvalid.
- rflags  out  3  {negative, zero, overflow} captured with rdata.

Behaviour:
- Handshake:
  - Core i holds req[i], aluop, portA and portB stable until it samples gnt[i]=1.
  - The transfer occurs in the cycle where req[i]&gnt[i].
  - gnt[i] never asserts without req[i].
- Arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the core NOT in last_gnt.
  - last_gnt updates to the granted core on each transfer and holds otherwise.
  - Reset value of last_gnt = 1, so core 0 wins the first contention.
  - A waiting core is granted within 1 cycle of losing, so there is no starvation.
  - flush[i] in the same cycle as req[i] suppresses gnt[i], and the other core may be granted instead.
- Issue stage, registered:
  - On a transfer, captures aluop, portA, portB, the owner id, and iss_v=1. Otherwise iss_v=0.
  - alu_* outputs are driven directly from the issue registers.
  - When iss_v=0, the issue registers hold their last value; there is no toggling.
- Response stage, registered:
  - When iss_v=1 and flush[owner]=0, capture alu_portOut into rdata and {negative, zero, overflow} into rflags, and set rvalid[owner]=1 for exactly one cycle.
  - If iss_v=1 and flush[owner]=1 in the same cycle, the op is dropped and no rvalid is produced.
  - When no response is produced, rdata and rflags hold and rvalid=0.
- Latency: transfer in cycle N → ALU evaluates in N+1 → rvalid/rdata visible in cycle N+2.
- Back-to-back: transfers in N and N+1 give responses in N+2 and N+3, in grant order and never reordered.
- At most one bit of rvalid is set per cycle.
- Flush:
  - flush[i] kills only ops owned by core i that are in the issue stage in that cycle.
  - A response already registered, i.e. rvalid visible this cycle, is not retracted.
  - Core j's ops are unaffected.
- Flags and overflow are passed through unmodified. The arbiter performs no arithmetic and no opcode checking; undefined opcodes pass through.
- Reset, asynchronous:
  - iss_v=0, issue registers=0 (aluop=0), rvalid=0, rdata=0, rflags=0, last_gnt=1.
  - gnt remains a pure function of req/flush/last_gnt.
  - Ops in flight at reset are lost with no response.
  - Deassertion is clean; the first transfer can occur in the first cycle after reset deasserts.

Test Plan:
- Core 0 only: ALU_ADD A=5 B=7 in cycle N → gnt=01 in N; rvalid=01, rdata=12, flags zero=0, negative=0 in N+2.
- Both request every cycle from reset, core 0 ALU_SUB 3−3 and core 1 ALU_OR 0xF0|0x0F → grants alternate 01,10,01…; core 0 results 0 with zero=1; core 1 results 0xFF; responses appear in grant order.
- Core 1 issues ALU_SLT A=0xFFFFFFFF B=1 and pulses flush=10 one cycle after the grant → no rvalid for that op. A simultaneous core 0 op issued in the next cycle still returns correctly.
- Core 0 held off for 3 cycles while core 1 streams → core 0 is granted within 1 cycle each time; never 2 consecutive losses.
- Assert RST mid-stream with 2 ops in flight → rvalid=0, rdata=0 immediately, no responses after release, next contention goes to core 0.
- ALU_ADD 0x80000000+0x80000000 → rdata=0, overflow=1, zero=1, negative=0, passed through unchanged.
